mem_port_arbiter: RTL

//  Shares one single-port unified memory between IF-stage instruction fetch and MEM-stage data access.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 16 +
 rtl/mem_port_arbiter_timeout_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory port arbiter: state codes, default
// no-op instruction and the access type presented for instruction fetches.
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_D_WAIT = 2'd1;
  localparam arb_state_t ARB_I_WAIT = 2'd2;
  localparam arb_state_t ARB_DONE   = 2'd3;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [2:0]  DM_FETCH = 3'b000;

  function automatic logic is_wait(input arb_state_t s);
    return (s == ARB_D_WAIT) || (s == ARB_I_WAIT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus: the arbiter is master, the unified memory is slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        dmtype;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, dmtype, input rdata, ack);
  modport slave  (input req, we, addr, wdata, dmtype, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Wait-cycle counter for one memory access; hit marks the last cycle the
// arbiter is willing to wait for an acknowledge.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count of the current wait cycle is 0-based, so hit lands on wait cycle TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !hit)
      count <= count + 1'b1;
  end

  assign hit = en && (count == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// serving data first and holding the pipeline stall until both are done.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_dmtype,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              err,
  mem_port_arbiter_if.master mem
);
  arb_state_t        state;
  logic              kill;
  logic              hit;
  logic              done;
  logic              timed_out;
  logic              issue;
  logic [DATA_W-1:0] eff_rdata;

  // A timeout is treated as an acknowledge that returned all ones.
  assign done      = is_wait(state) && (mem.ack || hit);
  assign timed_out = !mem.ack && hit;
  assign eff_rdata = mem.ack ? mem.rdata : '1;
  assign issue     = ((state == ARB_IDLE) && (d_req || i_req)) ||
                     ((state == ARB_D_WAIT) && done && i_req);
  assign stall     = ((state == ARB_IDLE) && (i_req || d_req)) || is_wait(state);

  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (issue),
    .en  (is_wait(state)),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      mem.req    <= 1'b0;
      mem.we     <= 1'b0;
      mem.addr   <= '0;
      mem.wdata  <= '0;
      mem.dmtype <= '0;
      i_rdata    <= NOP_INST;
      d_rdata    <= '0;
      err        <= 1'b0;
      kill       <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_req && i_flush)
            kill <= 1'b1;
          if (d_req) begin
            mem.req    <= 1'b1;
            mem.we     <= d_we;
            mem.addr   <= d_addr;
            mem.wdata  <= d_wdata;
            mem.dmtype <= d_dmtype;
            state      <= ARB_D_WAIT;
          end else if (i_req) begin
            mem.req    <= 1'b1;
            mem.we     <= 1'b0;
            mem.addr   <= i_addr;
            mem.wdata  <= '0;
            mem.dmtype <= DM_FETCH;
            state      <= ARB_I_WAIT;
          end
        end
        ARB_D_WAIT: begin
          if (done) begin
            d_rdata <= mem.we ? '0 : eff_rdata;
            if (timed_out)
              err <= 1'b1;
            // Chain the fetch straight onto the data access without an idle cycle.
            if (i_req) begin
              mem.we     <= 1'b0;
              mem.addr   <= i_addr;
              mem.wdata  <= '0;
              mem.dmtype <= DM_FETCH;
              state      <= ARB_I_WAIT;
            end else begin
              mem.req <= 1'b0;
              state   <= ARB_DONE;
            end
          end
        end
        ARB_I_WAIT: begin
          if (i_flush)
            kill <= 1'b1;
          if (done) begin
            i_rdata <= (kill || i_flush) ? NOP_INST : eff_rdata;
            if (timed_out)
              err <= 1'b1;
            mem.req <= 1'b0;
            state   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          kill  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
